alu_ext: RTL and testbench

Parametrised, registered successor to the 6502 combinational ALU. Adds operand width `WIDTH`, subtract and shift-left operations, and full N/Z/C/V flag outputs. Adds a multi-cycle BCD (decimal-mode) path for ADD/SUB that processes one nibble per clock. It sits between the register file and the status-register update logic of the execute stage, and uses a valid/ready handshake so the control FSM can stall on decimal operations.

---
 rtl/alu_ext_pkg.sv | 27 ++
 rtl/alu_ext_if.sv | 33 +++
 rtl/alu_ext_bcd_digit.sv | 33 +++
 rtl/alu_ext.sv | 182 ++++++++++++++++++
 tb/tb_alu_ext.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ext_pkg.sv
// Shared opcodes, FSM state encoding and decode helper for the extended ALU.
package alu_ext_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SR  = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SL  = 3'b101,
    OP_SUB = 3'b110
  } alu_op_e;

  // 3'b111 is reserved: it yields Y=0 with only Z set.
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BCD  = 1'b1
  } state_e;

  // Decimal mode only changes the behaviour of ADD and SUB.
  function automatic logic is_dec_op(logic [2:0] op, logic dec);
    return dec && ((op == OP_ADD) || (op == OP_SUB));
  endfunction

endpackage

// File: rtl/alu_ext_if.sv
// Request/result bundle between the execute-stage control and the ALU.
interface alu_ext_if import alu_ext_pkg::*; #(parameter int WIDTH = 8);
  // Handshake: a request transfers on a rising clock edge where
  // in_valid & in_ready are both 1; request fields are only looked at then.
  // There is no result backpressure: out_valid is a one-cycle pulse and
  // alu_Y/flags hold their value until the next pulse.
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic             alu_decimal;
  logic [WIDTH-1:0] alu_AI;
  logic [WIDTH-1:0] alu_BI;
  logic             alu_carry_in;
  logic             out_valid;
  logic [WIDTH-1:0] alu_Y;
  logic             alu_carry_out;
  logic             alu_overflow;
  logic             alu_negative;
  logic             alu_zero;
  state_e           dbg_state;

  modport master (
    output in_valid, alu_control, alu_decimal, alu_AI, alu_BI, alu_carry_in,
    input  in_ready, out_valid, alu_Y, alu_carry_out, alu_overflow,
           alu_negative, alu_zero, dbg_state
  );

  modport slave (
    input  in_valid, alu_control, alu_decimal, alu_AI, alu_BI, alu_carry_in,
    output in_ready, out_valid, alu_Y, alu_carry_out, alu_overflow,
           alu_negative, alu_zero, dbg_state
  );
endinterface

// File: rtl/alu_ext_bcd_digit.sv
// One BCD digit of add or subtract with chained carry/borrow.
// For subtract, c_i/c_o = 1 means "no borrow".
module bcd_digit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  input  logic       sub_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] sum;
  logic [5:0] diff;

  // Binary digit sum/difference followed by decimal correction.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
    diff = {2'b0, a_i} - {2'b0, b_i} - {5'b0, ~c_i};
    s_o  = sum[3:0];
    c_o  = 1'b0;
    if (sub_i) begin
      if (diff[5]) begin
        s_o = diff[3:0] + 4'd10;
        c_o = 1'b0;
      end else begin
        s_o = diff[3:0];
        c_o = 1'b1;
      end
    end else if (sum > 5'd9) begin
      s_o = sum[3:0] + 4'd6;
      c_o = 1'b1;
    end
  end
endmodule

// File: rtl/alu_ext.sv
// Registered ALU with binary ops and a nibble-serial decimal ADD/SUB path.
module alu_ext import alu_ext_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     resetn,
  alu_ext_if.slave bus
);
  localparam int NDIG = WIDTH / 4;
  localparam int CW   = $clog2(NDIG + 1);
  // Counter value of the extra cycle after the last digit: results publish
  // on the edge that ends it, and a new request may be taken on that edge.
  localparam logic [CW-1:0] LAST = CW'(NDIG);

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("alu_ext: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, y_q;
  logic             cin_q, dcar_q, bin_pend_q;
  logic             ov_q, c_q, v_q, n_q, z_q;
  logic             in_ready, accept, dec_req, digit_step, bcd_done;
  logic [WIDTH-1:0] b_x, bin_y;
  logic [WIDTH:0]   sum;
  logic             bin_c, bin_v;
  logic [3:0]       dig_s;
  logic             dig_c;

  assign in_ready   = (state_q == ST_IDLE) || (cnt_q == LAST);
  assign accept     = bus.in_valid && in_ready;
  assign dec_req    = is_dec_op(bus.alu_control, bus.alu_decimal);
  assign digit_step = (state_q == ST_BCD) && (cnt_q != LAST);
  assign bcd_done   = (state_q == ST_BCD) && (cnt_q == LAST);

  // Single digit unit; operands shift right one nibble per step so the
  // active digit is always at bits [3:0].
  bcd_digit u_digit (
    .a_i   (a_q[3:0]),
    .b_i   (b_q[3:0]),
    .c_i   (dcar_q),
    .sub_i (op_q == OP_SUB),
    .s_o   (dig_s),
    .c_o   (dig_c)
  );

  // Binary datapath on the captured operands.
  always_comb begin
    b_x   = (op_q == OP_SUB) ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin_q};
    bin_y = '0;
    bin_c = 1'b0;
    bin_v = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        bin_y = sum[WIDTH-1:0];
        bin_c = sum[WIDTH];
        bin_v = (a_q[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SR: begin
        bin_y = {cin_q, a_q[WIDTH-1:1]};
        bin_c = a_q[0];
      end
      OP_SL: begin
        bin_y = {a_q[WIDTH-2:0], cin_q};
        bin_c = a_q[WIDTH-1];
      end
      OP_AND: bin_y = a_q & b_q;
      OP_OR:  bin_y = a_q | b_q;
      OP_XOR: bin_y = a_q ^ b_q;
      default: bin_y = '0;
    endcase
  end

  // Next-state logic for the decimal sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && dec_req) begin
          state_d = ST_BCD;
          cnt_d   = '0;
        end
      end
      ST_BCD: begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (accept && dec_req) begin
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and digit counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture on accept; nibble shifting and partial-result build-up
  // (new digit enters at the top) while decimal digits are processed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      dcar_q     <= 1'b0;
      acc_q      <= '0;
      bin_pend_q <= 1'b0;
    end else begin
      bin_pend_q <= accept && !dec_req;
      if (accept) begin
        op_q   <= alu_op_e'(bus.alu_control);
        a_q    <= bus.alu_AI;
        b_q    <= bus.alu_BI;
        cin_q  <= bus.alu_carry_in;
        dcar_q <= bus.alu_carry_in;
        acc_q  <= '0;
      end else if (digit_step) begin
        a_q    <= a_q >> 4;
        b_q    <= b_q >> 4;
        acc_q  <= {dig_s, acc_q[WIDTH-1:4]};
        dcar_q <= dig_c;
      end
    end
  end

  // Result and flag registers, updated only when an operation completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ov_q <= 1'b0;
      y_q  <= '0;
      c_q  <= 1'b0;
      v_q  <= 1'b0;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      if (bin_pend_q) begin
        ov_q <= 1'b1;
        y_q  <= bin_y;
        c_q  <= bin_c;
        v_q  <= bin_v;
        n_q  <= bin_y[WIDTH-1];
        z_q  <= (bin_y == '0);
      end else if (bcd_done) begin
        ov_q <= 1'b1;
        y_q  <= acc_q;
        c_q  <= dcar_q;
        v_q  <= 1'b0;
        n_q  <= acc_q[WIDTH-1];
        z_q  <= (acc_q == '0);
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = ov_q;
  assign bus.alu_Y         = y_q;
  assign bus.alu_carry_out = c_q;
  assign bus.alu_overflow  = v_q;
  assign bus.alu_negative  = n_q;
  assign bus.alu_zero      = z_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_alu_ext.sv
// Bench for alu_ext: one 8-bit and one 16-bit instance on a shared clock.
module tb_alu_ext;
  import alu_ext_pkg::*;

  typedef struct {
    bit          w16;
    logic [2:0]  op;
    logic        dec;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] y;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[$];

  alu_ext_if #(.WIDTH(8))  if8 ();
  alu_ext_if #(.WIDTH(16)) if16 ();

  alu_ext #(.WIDTH(8))  u8  (.clk(clk), .resetn(resetn), .bus(if8));
  alu_ext #(.WIDTH(16)) u16 (.clk(clk), .resetn(resetn), .bus(if16));

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: the selected instance gets the request, the other stays idle.
  // When valid is 0 the operand fields carry random junk.
  task automatic drive(bit w16, logic v, logic [2:0] op, logic dec,
                       logic [15:0] a, logic [15:0] b, logic cin);
    if8.in_valid = 1'b0;
    if16.in_valid = 1'b0;
    if (w16) begin
      if16.in_valid     = v;
      if16.alu_control  = op;
      if16.alu_decimal  = dec;
      if16.alu_AI       = a;
      if16.alu_BI       = b;
      if16.alu_carry_in = cin;
    end else begin
      if8.in_valid     = v;
      if8.alu_control  = op;
      if8.alu_decimal  = dec;
      if8.alu_AI       = a[7:0];
      if8.alu_BI       = b[7:0];
      if8.alu_carry_in = cin;
    end
  endtask

  task automatic idle(bit w16);
    drive(w16, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
          1'($urandom_range(0, 1)));
  endtask

  task automatic sample(bit w16, output logic ov, output logic ir,
                        output logic [15:0] y, output logic c, output logic v,
                        output logic n, output logic z);
    if (w16) begin
      ov = if16.out_valid; ir = if16.in_ready; y = if16.alu_Y;
      c = if16.alu_carry_out; v = if16.alu_overflow;
      n = if16.alu_negative; z = if16.alu_zero;
    end else begin
      ov = if8.out_valid; ir = if8.in_ready; y = {8'h00, if8.alu_Y};
      c = if8.alu_carry_out; v = if8.alu_overflow;
      n = if8.alu_negative; z = if8.alu_zero;
    end
  endtask

  function automatic vec_t mk(bit w16, logic [2:0] op, logic dec, logic [15:0] a,
                              logic [15:0] b, logic cin, logic [15:0] y,
                              logic c, logic v, logic n, logic z);
    vec_t t;
    t.w16 = w16; t.op = op; t.dec = dec; t.a = a; t.b = b; t.cin = cin;
    t.y = y; t.c = c; t.v = v; t.n = n; t.z = z;
    return t;
  endfunction

  // Issue one op, measure latency and in_ready-low cycles, check the result.
  task automatic run_vec(vec_t t, string tag);
    int   lat, low, ndig, exp_lat, exp_low;
    logic ov, ir, c, v, n, z;
    logic [15:0] y;
    ndig    = t.w16 ? 4 : 2;
    exp_lat = (t.dec && (t.op == OP_ADD || t.op == OP_SUB)) ? ndig + 1 : 1;
    exp_low = (exp_lat == 1) ? 0 : ndig;
    @(negedge clk);
    drive(t.w16, 1'b1, t.op, t.dec, t.a, t.b, t.cin);
    @(posedge clk);
    @(negedge clk);
    idle(t.w16);
    sample(t.w16, ov, ir, y, c, v, n, z);
    low = ir ? 0 : 1;
    lat = 0;
    ov  = 1'b0;
    while (!ov && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      sample(t.w16, ov, ir, y, c, v, n, z);
      if (!ov && !ir) low++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ready_low"}, low, exp_low);
    chk({tag, "_ready_at_done"}, {31'd0, ir}, 1);
    chk({tag, "_y"}, {16'd0, y}, {16'd0, t.y});
    chk({tag, "_cvnz"}, {28'd0, c, v, n, z}, {28'd0, t.c, t.v, t.n, t.z});
    @(posedge clk);
    @(negedge clk);
    sample(t.w16, ov, ir, y, c, v, n, z);
    chk({tag, "_pulse_len"}, {31'd0, ov}, 0);
    chk({tag, "_y_held"}, {16'd0, y}, {16'd0, t.y});
  endtask

  initial begin
    logic ov, ir, c, v, n, z;
    logic [15:0] y;
    int pulses;

    // Reset.
    resetn = 1'b0;
    idle(1'b0);
    idle(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    sample(1'b0, ov, ir, y, c, v, n, z);
    chk("rst8_outs", {ov, ir, y, c, v, n, z}, {1'b0, 1'b1, 16'h0, 4'h0});
    sample(1'b1, ov, ir, y, c, v, n, z);
    chk("rst16_outs", {ov, ir, y, c, v, n, z}, {1'b0, 1'b1, 16'h0, 4'h0});
    chk("rst16_state", if16.dbg_state, ST_IDLE);

    // Directed vectors: w16, op, dec, A, B, cin -> Y, C, V, N, Z.
    vecs.push_back(mk(0, OP_ADD, 0, 16'h50, 16'h50, 0, 16'hA0, 0, 1, 1, 0));
    vecs.push_back(mk(0, OP_ADD, 1, 16'h58, 16'h46, 0, 16'h04, 1, 0, 0, 0));
    vecs.push_back(mk(0, OP_SUB, 1, 16'h42, 16'h15, 1, 16'h27, 1, 0, 0, 0));
    vecs.push_back(mk(0, OP_SUB, 1, 16'h15, 16'h42, 1, 16'h73, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_SR,  0, 16'h81, 16'h00, 1, 16'hC0, 1, 0, 1, 0));
    vecs.push_back(mk(0, OP_SL,  0, 16'h81, 16'h00, 0, 16'h02, 1, 0, 0, 0));
    vecs.push_back(mk(0, OP_SUB, 0, 16'h50, 16'hB0, 1, 16'hA0, 0, 1, 1, 0));
    vecs.push_back(mk(0, OP_SUB, 0, 16'h05, 16'h05, 1, 16'h00, 1, 0, 0, 1));
    vecs.push_back(mk(0, OP_AND, 0, 16'hF0, 16'h3C, 1, 16'h30, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_OR,  0, 16'h0F, 16'h80, 0, 16'h8F, 0, 0, 1, 0));
    vecs.push_back(mk(0, OP_XOR, 0, 16'hAA, 16'hAA, 0, 16'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, OP_RSVD, 0, 16'hFF, 16'hFF, 1, 16'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, OP_ADD, 0, 16'hFF, 16'h01, 0, 16'h00, 1, 0, 0, 1));
    vecs.push_back(mk(0, OP_AND, 1, 16'h99, 16'h0F, 0, 16'h09, 0, 0, 0, 0));
    vecs.push_back(mk(0, OP_ADD, 0, 16'h7F, 16'h00, 1, 16'h80, 0, 1, 1, 0));
    vecs.push_back(mk(1, OP_ADD, 1, 16'h9999, 16'h0001, 0, 16'h0000, 1, 0, 0, 1));
    vecs.push_back(mk(1, OP_ADD, 1, 16'h1234, 16'h5678, 0, 16'h6912, 0, 0, 0, 0));
    vecs.push_back(mk(1, OP_SUB, 1, 16'h1000, 16'h0001, 1, 16'h0999, 1, 0, 0, 0));
    vecs.push_back(mk(1, OP_SUB, 0, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back binary ops: SR then SL, two consecutive pulses.
    exp_q.push_back(16'hC0);
    exp_q.push_back(16'h02);
    @(negedge clk);
    drive(0, 1, OP_SR, 0, 16'h81, 16'h00, 1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, OP_SL, 0, 16'h81, 16'h00, 0);
    pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) idle(1'b0);
      sample(1'b0, ov, ir, y, c, v, n, z);
      if (ov) begin
        pulses++;
        chk($sformatf("b2b_bin_k%0d_when", k), k, pulses);
        if (exp_q.size() != 0) chk($sformatf("b2b_bin_k%0d_y", k), y, exp_q.pop_front());
        else chk("b2b_bin_extra", pulses, 2);
        chk($sformatf("b2b_bin_k%0d_c", k), c, 1);
      end
    end
    chk("b2b_bin_pulses", pulses, 2);

    // Decimal op followed by a decimal op accepted on the completion edge.
    exp_q.delete();
    exp_q.push_back(16'h04);
    exp_q.push_back(16'h27);
    @(negedge clk);
    drive(0, 1, OP_ADD, 1, 16'h58, 16'h46, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, OP_SUB, 1, 16'h42, 16'h15, 1);
    pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) idle(1'b0);
      sample(1'b0, ov, ir, y, c, v, n, z);
      if (k == 1) chk("b2b_dec_ready_k1", ir, 0);
      if (k == 2) chk("b2b_dec_ready_k2", ir, 1);
      if (ov) begin
        pulses++;
        chk($sformatf("b2b_dec_k%0d_when", k), k, 3 * pulses);
        if (exp_q.size() != 0) chk($sformatf("b2b_dec_k%0d_y", k), y, exp_q.pop_front());
        else chk("b2b_dec_extra", pulses, 2);
      end
    end
    chk("b2b_dec_pulses", pulses, 2);

    // Reset dropped two edges into a 16-bit decimal op aborts it.
    @(negedge clk);
    drive(1, 1, OP_ADD, 1, 16'h9999, 16'h0001, 0);
    @(posedge clk);
    @(negedge clk);
    idle(1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    sample(1'b1, ov, ir, y, c, v, n, z);
    chk("abort_outs", {ov, ir, y, c, v, n, z}, {1'b0, 1'b1, 16'h0, 4'h0});
    chk("abort_state", if16.dbg_state, ST_IDLE);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sample(1'b1, ov, ir, y, c, v, n, z);
      if (ov || !ir) pulses++;
    end
    chk("abort_quiet", pulses, 0);
    run_vec(mk(1, OP_ADD, 0, 16'h1234, 16'h1111, 1, 16'h2346, 0, 0, 0, 0), "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
